// File: rtl/pipe_add.sv
// Pipelined segmented adder: WIDTH-bit a+b+ci, one SEG-bit segment per stage, valid/ready on both ends.
// Optional subtract mode and signed-overflow output when PIPE_ADD_SUB_EN is defined.
module pipe_add #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef PIPE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef PIPE_ADD_SUB_EN
    output logic             co,
    output logic             ovf
`else
    output logic             co
`endif
);
    localparam int NSTG = WIDTH / SEG;
    localparam int SW   = SEG + 1;

    // Index k of these arrays is what stage k consumes; index k+1 is what stage k holds.
    logic [WIDTH-1:0] opa_w [NSTG];
    logic [WIDTH-1:0] opb_w [NSTG];
    logic [WIDTH-1:0] sum_w [NSTG+1];
    logic [NSTG:0]    cy_w;
    logic [NSTG:0]    vld_w;
    logic [NSTG:0]    rdy;

    assign opa_w[0] = a;
    assign sum_w[0] = '0;
    assign vld_w[0] = in_valid;
`ifdef PIPE_ADD_SUB_EN
    // Subtract as a + ~b + 1; the external carry-in is ignored in that mode.
    assign opb_w[0] = sub ? ~b : b;
    assign cy_w[0]  = sub | ci;
`else
    assign opb_w[0] = b;
    assign cy_w[0]  = ci;
`endif

    always_comb begin
        rdy       = '0;
        rdy[NSTG] = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            rdy[k] = !vld_w[k+1] | rdy[k+1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_w[NSTG];
    assign s         = sum_w[NSTG];
    assign co        = cy_w[NSTG];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [SEG:0]     seg_sum;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        assign seg_sum = {1'b0, opa_w[k][SEG-1:0]} + {1'b0, opb_w[k][SEG-1:0]} + SW'(cy_w[k]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy[k]) begin
                v_q <= vld_w[k];
                c_q <= seg_sum[SEG];
                s_q <= sum_w[k] | (WIDTH'(seg_sum[SEG-1:0]) << (SEG * k));
            end
        end

        assign vld_w[k+1] = v_q;
        assign cy_w[k+1]  = c_q;
        assign sum_w[k+1] = s_q;

        // Remaining operand segments travel shifted down so the next segment is always at bit 0.
        if (k < NSTG - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy[k]) begin
                    a_q <= opa_w[k] >> SEG;
                    b_q <= opb_w[k] >> SEG;
                end
            end

            assign opa_w[k+1] = a_q;
            assign opb_w[k+1] = b_q;
        end

`ifdef PIPE_ADD_SUB_EN
        if (k == NSTG - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (rdy[k]) begin
                    ovf_q <= (opa_w[k][SEG-1] == opb_w[k][SEG-1]) && (seg_sum[SEG-1] != opa_w[k][SEG-1]);
                end
            end

            assign ovf = ovf_q;
        end
`endif
    end

endmodule

// File: tb/tb_pipe_add.sv
// Scoreboard bench for pipe_add (32/8 main instance, 16/16 single-stage instance).
module tb_pipe_add;
    localparam int W  = 32;
    localparam int SG = 8;
    localparam int NS = W / SG;
    localparam int W1 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, ci, out_valid, out_ready, co;
    logic [W-1:0]  a, b, s;
    logic          sub, ovf;

    logic          in_valid1, in_ready1, ci1, out_valid1, out_ready1, co1;
    logic [W1-1:0] a1, b1, s1;
    logic          sub1, ovf1;

    pipe_add #(.WIDTH(W), .SEG(SG)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci),
`ifdef PIPE_ADD_SUB_EN
        .sub(sub), .ovf(ovf),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co)
    );

    pipe_add #(.WIDTH(W1), .SEG(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .ci(ci1),
`ifdef PIPE_ADD_SUB_EN
        .sub(sub1), .ovf(ovf1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .s(s1), .co(co1)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mci, input logic msub);
        exp_t            e;
        longint unsigned ua, ub, r;
        longint          sa, sb, sr, maxs, mins;
        ua   = 64'(ma);
        ub   = 64'(mb);
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        maxs = (longint'(1) << (W - 1)) - 1;
        mins = -(longint'(1) << (W - 1));
        if (msub) begin
            r    = ua - ub;
            e.co = (ua >= ub);
            sr   = sa - sb;
        end else begin
            r    = ua + ub + 64'(mci);
            e.co = r[W];
            sr   = sa + sb + longint'(mci);
        end
        e.s   = r[W-1:0];
        e.ovf = (sr > maxs) || (sr < mins);
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(s), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                n_pop++;
                check("s", 64'(s), 64'(e.s));
                check("co", 64'(co), 64'(e.co));
`ifdef PIPE_ADD_SUB_EN
                check("ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci, input logic vsub);
        bit hs = 1'b0;
        int n  = 0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        ci       = vci;
        sub      = vsub;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = in_ready;
            if (hs) begin
                exp_q.push_back(model(va, vb, vci, vsub));
                n_push++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) check("send_timeout", 64'(n), 64'(0));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int            n, acc;
        bit            hs, held;
        logic [W-1:0]  held_s;
        logic          held_co;
        longint        t0;
        logic [W1:0]   r1;

        in_valid = 0; a = '0; b = '0; ci = 0; sub = 0; out_ready = 1'b1;
        in_valid1 = 0; a1 = '0; b1 = '0; ci1 = 0; sub1 = 0; out_ready1 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_s", 64'(s), 64'(0));
        check("rst_co", 64'(co), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid1", 64'(out_valid1), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry ripple through every stage, with latency measurement
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            n++;
        end
        check("ripple_latency", 64'(n), 64'(NS));
        check("ripple_s", 64'(s), 64'(0));
        check("ripple_co", 64'(co), 64'(1));
        @(posedge clk);
        #1;

        // Back-to-back random stream at full throughput
        t0 = $time;
        for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        check("stream_cycles", 64'(($time - t0) / 10), 64'(100));
        drain();

        // Backpressure: out_ready low for 6 cycles with input always offered
        out_ready = 1'b0;
        acc = 0; held = 1'b0; hs = 1'b0; held_s = '0; held_co = 1'b0;
        in_valid = 1'b1; a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); sub = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hs = in_ready;
            if (hs) begin
                exp_q.push_back(model(a, b, ci, 1'b0));
                n_push++;
                acc++;
            end
            if (out_valid) begin
                if (!held) begin
                    held_s = s; held_co = co; held = 1'b1;
                end else begin
                    check("hold_s", 64'(s), 64'(held_s));
                    check("hold_co", 64'(co), 64'(held_co));
                end
            end
            @(posedge clk);
            #1;
            if (hs) begin
                a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(NS));
        check("bp_in_ready_low", 64'(hs), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        drain();

        // Bubbles with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            @(posedge clk);
            #1;
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();
        check("bubble_count", 64'(n_pop), 64'(n_push));

`ifdef PIPE_ADD_SUB_EN
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
`endif

        // Reset mid-stream: results in flight must vanish
        n_push = 0; n_pop = 0;
        out_ready = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
        send(32'h5555_5555, 32'h6666_6666, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_s", 64'(s), 64'(0));
        check("midrst_co", 64'(co), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_pops", 64'(n_pop), 64'(0));
        send(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0);
        drain();

        // Single-stage instance: carry ripple and one random op, latency 1
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                a1 = 16'hFFFF; b1 = 16'h0000; ci1 = 1'b1;
            end else begin
                a1 = 16'($urandom); b1 = 16'($urandom); ci1 = 1'($urandom_range(0, 1));
            end
            r1 = {1'b0, a1} + {1'b0, b1} + 17'(ci1);
            in_valid1 = 1'b1;
            @(negedge clk);
            check("n1_in_ready", 64'(in_ready1), 64'(1));
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            @(negedge clk);
            check("n1_out_valid", 64'(out_valid1), 64'(1));
            check("n1_s", 64'(s1), 64'(r1[W1-1:0]));
            check("n1_co", 64'(co1), 64'(r1[W1]));
            @(posedge clk);
            #1;
        end
        check("n1_idle", 64'(out_valid1), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
